// File: rtl/uart_word_loader.sv
// rtl/uart_word_loader.sv - UART program loader: header N, 4*N LE data bytes -> imem words, XOR checksum ACK.
// Optional UART_LOADER_ECHO_EN echoes every popped byte to the TX FIFO one cycle after its pop.
module uart_word_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [7:0]        r_data,
  output logic              rd,
  output logic [7:0]        w_data,
  output logic              wr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              loaded
);

  typedef enum logic [2:0] {IDLE, HDR, LOAD, WRITE, ACK} state_t;

  state_t      state, state_next;
  logic [7:0]  words_left;
  logic [7:0]  checksum;
  logic [1:0]  byte_cnt;
  logic        rd_q;
  logic        pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_empty) begin
          pop        = 1'b1;
          state_next = HDR;
        end
      end
      HDR: state_next = (words_left == 8'd0) ? ACK : LOAD;
      LOAD: begin
        // One idle cycle after every pop lets the FIFO empty flag catch up.
        if (!rx_empty && !rd_q) begin
          pop = 1'b1;
          if (byte_cnt == 2'd3) state_next = WRITE;
        end
      end
      WRITE: begin
        mem_we     = 1'b1;
        state_next = (words_left == 8'd1) ? ACK : LOAD;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Keep the pop strobe quiet while reset is held, even with a non-empty FIFO.
  assign rd = pop & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_left <= 8'd0;
      checksum   <= 8'd0;
      byte_cnt   <= 2'd0;
      rd_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      loaded     <= 1'b0;
    end else begin
      rd_q <= pop;
      case (state)
        IDLE: begin
          if (pop) begin
            words_left <= r_data;
            checksum   <= r_data;
            loaded     <= 1'b0;
          end
        end
        HDR: begin
          byte_cnt <= 2'd0;
          mem_addr <= '0;
        end
        LOAD: begin
          if (pop) begin
            mem_wdata[{byte_cnt, 3'b000} +: 8] <= r_data;
            checksum <= checksum ^ r_data;
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        WRITE: begin
          mem_addr   <= mem_addr + 1'b1;
          words_left <= words_left - 8'd1;
        end
        ACK:     loaded <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef UART_LOADER_ECHO_EN
  logic       echo_valid;
  logic [7:0] echo_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_valid <= 1'b0;
      echo_byte  <= 8'd0;
    end else begin
      echo_valid <= pop;
      echo_byte  <= r_data;
    end
  end

  // An echo can never land in ACK: ACK always follows HDR or WRITE, neither of which pops.
  assign wr     = (state == ACK) | echo_valid;
  assign w_data = (state == ACK) ? checksum : (echo_valid ? echo_byte : 8'h00);
`else
  assign wr     = (state == ACK);
  assign w_data = (state == ACK) ? checksum : 8'h00;
`endif

endmodule

// File: tb/tb_uart_word_loader.sv
// tb/tb_uart_word_loader.sv - directed self-checking bench for uart_word_loader with a byte-queue RX FIFO model.
module tb_uart_word_loader;

`ifdef UART_LOADER_ECHO_EN
  localparam int ECHO = 1;
`else
  localparam int ECHO = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        rd;
  logic [7:0]  w_data;
  logic        wr;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        loaded;

  uart_word_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd(rd),
    .w_data(w_data), .wr(wr), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .loaded(loaded)
  );

  always #5 clk = ~clk;

  // RX FIFO model: initial block appends at src_wr, the FIFO process consumes at src_rd.
  logic [7:0] src_mem [0:255];
  int         src_wr;
  int         src_rd;
  int         src_nxt;
  logic       gap_en = 1'b0;

  always @(posedge clk) begin
    src_nxt  = src_rd + (rd ? 1 : 0);
    src_rd   <= src_nxt;
    rx_empty <= (src_nxt >= src_wr) || (gap_en && ($urandom_range(0, 1) == 0));
    r_data   <= src_mem[src_nxt[7:0]];
  end

  // Output monitor, sampled on the falling edge.
  int          cyc;
  logic        rd_prev;
  int          consec_rd;
  int          rd_empty;
  int          rd_cyc_log[$];
  logic [7:0]  wr_log[$];
  int          wr_cyc_log[$];
  int          we_addr_log[$];
  logic [31:0] we_data_log[$];
  int          we_cyc_log[$];

  always @(negedge clk) begin
    if (reset) begin
      rd_prev = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (rd) begin
        rd_cyc_log.push_back(cyc);
        if (rd_prev) consec_rd = consec_rd + 1;
        if (rx_empty) rd_empty = rd_empty + 1;
      end
      if (wr) begin
        wr_log.push_back(w_data);
        wr_cyc_log.push_back(cyc);
      end
      if (mem_we) begin
        we_addr_log.push_back(int'(mem_addr));
        we_data_log.push_back(mem_wdata);
        we_cyc_log.push_back(cyc);
      end
      rd_prev = rd;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [7:0] b[$]);
    foreach (b[i]) begin
      src_mem[src_wr[7:0]] = b[i];
      src_wr++;
    end
  endtask

  task automatic clear_logs();
    rd_cyc_log.delete();
    wr_log.delete();
    wr_cyc_log.delete();
    we_addr_log.delete();
    we_data_log.delete();
    we_cyc_log.delete();
    consec_rd = 0;
    rd_empty  = 0;
  endtask

  task automatic wait_rd(input int n, input string tag);
    int k = 0;
    while (rd_cyc_log.size() < n && k < 600) begin
      tick();
      k++;
    end
    check({tag, "_rd_timeout"}, 32'(rd_cyc_log.size() >= n), 32'd1);
  endtask

  task automatic wait_wr(input int n, input string tag);
    int k = 0;
    while (wr_log.size() < n && k < 600) begin
      tick();
      k++;
    end
    check({tag, "_wr_timeout"}, 32'(wr_log.size() >= n), 32'd1);
    repeat (4) tick();
  endtask

  task automatic check_three_words(input string tag);
    check({tag, "_we_count"}, 32'(we_addr_log.size()), 32'd3);
    if (we_addr_log.size() == 3) begin
      check({tag, "_addr0"}, 32'(we_addr_log[0]), 32'd0);
      check({tag, "_addr1"}, 32'(we_addr_log[1]), 32'd1);
      check({tag, "_addr2"}, 32'(we_addr_log[2]), 32'd2);
      check({tag, "_data0"}, we_data_log[0], 32'h04030201);
      check({tag, "_data1"}, we_data_log[1], 32'h08070605);
      check({tag, "_data2"}, we_data_log[2], 32'h0C0B0A09);
      check({tag, "_ack_after_write"}, 32'(wr_cyc_log[wr_cyc_log.size()-1]), 32'(we_cyc_log[2] + 1));
    end
    check({tag, "_ack"}, 32'(wr_log[wr_log.size()-1]), 32'h0F);
    check({tag, "_consec_rd"}, 32'(consec_rd), 32'd0);
    check({tag, "_rd_when_empty"}, 32'(rd_empty), 32'd0);
  endtask

  logic [7:0] t1_bytes[$] = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
  logic [7:0] t3_bytes[$] = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                              8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_w_data", 32'(w_data), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    reset = 1'b0;
    tick();

    // N=1: 78 56 34 12
    clear_logs();
    push_bytes(t1_bytes);
    wait_wr(1 + ECHO * 5, "t1");
    check("t1_we_count", 32'(we_addr_log.size()), 32'd1);
    if (we_addr_log.size() == 1) begin
      check("t1_addr", 32'(we_addr_log[0]), 32'd0);
      check("t1_data", we_data_log[0], 32'h12345678);
      check("t1_we_after_pop", 32'(we_cyc_log[0]), 32'(rd_cyc_log[4] + 1));
    end
    check("t1_wr_count", 32'(wr_log.size()), 32'(1 + ECHO * 5));
    check("t1_ack", 32'(wr_log[wr_log.size()-1]), 32'h09);
    check("t1_loaded", 32'(loaded), 32'd1);
    if (ECHO == 1 && wr_log.size() == 6) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("t1_echo%0d", i), 32'(wr_log[i]), 32'(t1_bytes[i]));
        check($sformatf("t1_echo_cyc%0d", i), 32'(wr_cyc_log[i]), 32'(rd_cyc_log[i] + 1));
      end
    end

    // N=0: immediate ACK of 0x00, loaded drops on the header pop
    clear_logs();
    push_bytes('{8'h00});
    wait_rd(1, "t2");
    tick();
    check("t2_loaded_clear", 32'(loaded), 32'd0);
    wait_wr(1 + ECHO, "t2");
    check("t2_ack", 32'(wr_log[wr_log.size()-1]), 32'h00);
    check("t2_ack_cyc", 32'(wr_cyc_log[wr_cyc_log.size()-1]), 32'(rd_cyc_log[0] + 2));
    check("t2_we_count", 32'(we_addr_log.size()), 32'd0);
    check("t2_loaded", 32'(loaded), 32'd1);

    // N=3 with FIFO pre-filled
    clear_logs();
    push_bytes(t3_bytes);
    wait_wr(1 + ECHO * 13, "t3");
    check("t3_first_data_pop", 32'(rd_cyc_log[1] - rd_cyc_log[0]), 32'd2);
    check_three_words("t3");

    // Same stream with random FIFO gaps
    clear_logs();
    gap_en = 1'b1;
    push_bytes(t3_bytes);
    wait_wr(1 + ECHO * 13, "t4");
    gap_en = 1'b0;
    check_three_words("t4");

    // Reset after 2 of 4 data bytes, then a clean N=1 transfer
    clear_logs();
    push_bytes('{8'h01, 8'h11, 8'h22});
    wait_rd(3, "t5");
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("t5_rst_rd", 32'(rd), 32'd0);
    check("t5_rst_wr", 32'(wr), 32'd0);
    check("t5_rst_w_data", 32'(w_data), 32'd0);
    check("t5_rst_mem_we", 32'(mem_we), 32'd0);
    check("t5_rst_mem_wdata", mem_wdata, 32'd0);
    check("t5_rst_loaded", 32'(loaded), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    push_bytes('{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    wait_wr(1 + ECHO * 8, "t5");
    check("t5_we_count", 32'(we_addr_log.size()), 32'd1);
    if (we_addr_log.size() == 1) begin
      check("t5_addr", 32'(we_addr_log[0]), 32'd0);
      check("t5_data", we_data_log[0], 32'hDDCCBBAA);
    end
    check("t5_wr_count", 32'(wr_log.size()), 32'(1 + ECHO * 8));
    check("t5_ack", 32'(wr_log[wr_log.size()-1]), 32'h01);
    check("t5_loaded", 32'(loaded), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
